// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes engine: LANES combined forward/inverse S-box lanes
// process a captured 128-bit state in place over BEATS cycles, then hold the result.

module sbox_lane (
    input  logic       dir,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = gf_mul(x, x);
        r = t;
        for (int i = 0; i < 6; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] y);
        return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]}
                 ^ {y[3:0], y[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] pre;
    logic [7:0] inv;

    assign pre  = dir ? inv_affine(din) : din;
    assign inv  = gf_inv(pre);
    assign dout = dir ? inv : affine(inv);
endmodule

// state | meaning
// IDLE  | in_ready high, waiting for a state to capture
// BUSY  | substituting LANES bytes per cycle, byte 0 first
// DONE  | result held on out_state until out_ready
module subbytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dir,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_dir,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("subbytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    logic [1:0]        state;
    logic [15:0][7:0]  work;
    logic [15:0][7:0]  next_work;
    logic              dir_q;
    logic [CW-1:0]     beat;
    logic [7:0]        lane_in  [LANES];
    logic [7:0]        lane_out [LANES];

    // byte k of the state lives in work[15-k] so that byte 0 is the MSB
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_in[j] = work[4'(15 - (int'(beat) * LANES + j))];
        end
    end

    always_comb begin
        next_work = work;
        for (int j = 0; j < LANES; j++) begin
            next_work[4'(15 - (int'(beat) * LANES + j))] = lane_out[j];
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            sbox_lane u_lane (
                .dir  (dir_q),
                .din  (lane_in[g]),
                .dout (lane_out[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            work  <= '0;
            dir_q <= 1'b0;
            beat  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        dir_q <= in_dir;
                        beat  <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    work <= next_work;
                    if (beat == CW'(BEATS - 1)) begin
                        beat  <= '0;
                        state <= S_DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_state = work;
    assign out_dir   = dir_q;
endmodule

// File: tb/tb_subbytes_iter.sv
// Scoreboard bench for subbytes_iter: one instance per legal LANES value,
// expected results come from a FIPS-197 S-box table.

module tb_subbytes_iter;
    localparam int NDUT = 5;

    localparam logic [2047:0] SBOX_HEX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_dir;
    logic         out_ready;
    logic [127:0] in_state;
    logic         in_valid_v  [NDUT];
    logic         in_ready_v  [NDUT];
    logic         out_valid_v [NDUT];
    logic         out_dir_v   [NDUT];
    logic         busy_v      [NDUT];
    logic [127:0] out_state_v [NDUT];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            subbytes_iter #(.LANES(1 << g)) u_dut (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_valid  (in_valid_v[g]),
                .in_ready  (in_ready_v[g]),
                .in_dir    (in_dir),
                .in_state  (in_state),
                .out_valid (out_valid_v[g]),
                .out_ready (out_ready),
                .out_state (out_state_v[g]),
                .out_dir   (out_dir_v[g]),
                .busy      (busy_v[g])
            );
        end
    endgenerate

    typedef struct {
        logic [127:0] st;
        logic         dir;
        int           acc;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         sel      = 2;
    int         n_acc    = 0;
    bit         seen     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] sub_state(input logic [127:0] s, input logic dir);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            b = s[127-8*k -: 8];
            r[127-8*k -: 8] = dir ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Monitor: latency at first out_valid, data compared on the handshake
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (in_valid_v[sel] && in_ready_v[sel]) n_acc++;
                if (out_valid_v[sel]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 128'd1, 128'd0);
                    end else begin
                        if (!seen) begin
                            check("latency", 128'(cyc - sb[0].acc), 128'(16 >> sel));
                            seen = 1'b1;
                        end
                        if (out_ready) begin
                            check("out_state", out_state_v[sel], sb[0].st);
                            check("out_dir", 128'(out_dir_v[sel]), 128'(sb[0].dir));
                            void'(sb.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int idx, input logic [127:0] st, input logic dir, input logic [127:0] exp);
        exp_t e;
        in_state        = st;
        in_dir          = dir;
        in_valid_v[idx] = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready_v[idx]) begin
                e.st  = exp;
                e.dir = dir;
                e.acc = cyc + 1;
                sb.push_back(e);
                @(posedge clk);
                #1 in_valid_v[idx] = 1'b0;
                return;
            end
        end
        check("accept_timeout", 128'd0, 128'd1);
        in_valid_v[idx] = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("drain_queue_empty", 128'(sb.size()), 128'd0);
        sb.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2047:0] tabv;
        logic [127:0]  orig, fx, b_state, a_exp;
        int            acc0, last, cnt;

        tabv = SBOX_HEX;
        for (int i = 0; i < 256; i++) begin
            fwd_tab[i] = tabv[2047-8*i -: 8];
            inv_tab[fwd_tab[i]] = i[7:0];
        end

        reset_n   = 1'b0;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        in_state  = '0;
        for (int i = 0; i < NDUT; i++) in_valid_v[i] = 1'b0;
        #22;
        check("rst_in_ready", 128'(in_ready_v[2]), 128'd1);
        check("rst_out_valid", 128'(out_valid_v[2]), 128'd0);
        check("rst_busy", 128'(busy_v[2]), 128'd0);
        check("rst_out_state", out_state_v[2], 128'd0);
        check("rst_out_dir", 128'(out_dir_v[2]), 128'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: asynchronous reset during the second beat, LANES=4
        sel           = 2;
        in_state      = '0;
        in_dir        = 1'b0;
        in_valid_v[2] = 1'b1;
        @(negedge clk);
        check("t1_ready_before_accept", 128'(in_ready_v[2]), 128'd1);
        @(posedge clk);
        #1 in_valid_v[2] = 1'b0;
        in_state = '1;
        in_dir   = 1'b1;
        @(posedge clk);
        #1 check("t1_busy_mid", 128'(busy_v[2]), 128'd1);
        reset_n = 1'b0;
        #1;
        check("t1_async_busy", 128'(busy_v[2]), 128'd0);
        check("t1_async_in_ready", 128'(in_ready_v[2]), 128'd1);
        check("t1_async_out_valid", 128'(out_valid_v[2]), 128'd0);
        check("t1_async_out_state", out_state_v[2], 128'd0);
        check("t1_async_out_dir", 128'(out_dir_v[2]), 128'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(2, 128'd0, 1'b0, {16{8'h63}});
        drain();

        // Tests 2 and 3: fixed vectors, LANES=4
        send(2, {4{32'h0001_53ff}}, 1'b0, {4{32'h637c_ed16}});
        drain();
        send(2, {4{32'h637c_ed16}}, 1'b1, {4{32'h0001_53ff}});
        drain();

        // Test 4: forward then inverse round trip for LANES 1, 2, 8, 16
        for (int gi = 0; gi < NDUT; gi++) begin
            if (gi != 2) begin
                sel = gi;
                for (int n = 0; n < 200; n++) begin
                    orig = rnd128();
                    fx   = sub_state(orig, 1'b0);
                    send(gi, orig, 1'b0, fx);
                    send(gi, fx, 1'b1, orig);
                end
                drain();
            end
        end

        // Test 5: backpressure with in_valid held and in_state toggling, LANES=4
        sel       = 2;
        out_ready = 1'b0;
        orig      = rnd128();
        a_exp     = sub_state(orig, 1'b0);
        send(2, orig, 1'b0, a_exp);
        in_valid_v[2] = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (out_valid_v[2]) break;
        end
        check("t5_out_valid_rise", 128'(out_valid_v[2]), 128'd1);
        acc0 = n_acc;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1 in_state = rnd128();
            in_dir = ~in_dir;
            @(negedge clk);
            check("t5_hold_valid", 128'(out_valid_v[2]), 128'd1);
            check("t5_hold_ready", 128'(in_ready_v[2]), 128'd0);
            check("t5_hold_state", out_state_v[2], a_exp);
            check("t5_hold_dir", 128'(out_dir_v[2]), 128'd0);
        end
        @(posedge clk);
        b_state = rnd128();
        #1 in_state = b_state;
        in_dir    = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (in_ready_v[2]) begin
                sb.push_back('{st: sub_state(b_state, 1'b0), dir: 1'b0, acc: cyc + 1});
                break;
            end
        end
        @(posedge clk);
        #1 in_valid_v[2] = 1'b0;
        drain();
        check("t5_single_accept", 128'(n_acc - acc0), 128'd1);

        // Test 6: continuous in_valid and out_ready, LANES=16
        sel           = 4;
        out_ready     = 1'b1;
        in_state      = rnd128();
        in_dir        = 1'($urandom);
        in_valid_v[4] = 1'b1;
        last          = -1;
        cnt           = 0;
        for (int t = 0; t < 200 && cnt < 20; t++) begin
            @(negedge clk);
            if (in_ready_v[4]) begin
                sb.push_back('{st: sub_state(in_state, in_dir), dir: in_dir, acc: cyc + 1});
                if (last >= 0) check("t6_interval", 128'(cyc + 1 - last), 128'd3);
                last = cyc + 1;
                cnt++;
                @(posedge clk);
                #1 in_state = rnd128();
                in_dir = 1'($urandom);
            end
        end
        in_valid_v[4] = 1'b0;
        check("t6_accept_count", 128'(cnt), 128'd20);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
